// File: rtl/tt_um_akaur014_count_checker_if.sv
// Pin bundle of the count checker tile. The master drives the dedicated
// inputs and the slave (the checker) drives the output and bidirectional pins.
interface tt_um_akaur014_count_checker_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;

  modport master (output ui_in, uio_in, ena, input  uo_out, uio_out, uio_oe);
  modport slave  (input  ui_in, uio_in, ena, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_akaur014_count_checker.sv
// Sequence checker for a 4-bit pin-level counter.
// It samples the count and step strobe, predicts the next value (+1 or -1),
// and reports match/mismatch pulses, an error count, a wrap count, and
// locked/fault status.
// Optional feature macro: CHECKER_RESYNC_EN. When it is defined, a mismatch
// re-bases the prediction on the observed value.
module tt_um_akaur014_count_checker #(
  parameter int FAULT_THRESH = 3,  // consecutive mismatches to FAULT (1..15)
  parameter int SYNC_STAGES  = 2   // synchronizer depth (>= 2)
) (
  input logic                               clk,
  input logic                               rst_n,
  tt_um_akaur014_count_checker_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, SYNC, TRACK, FAULT} state_t;

  // Predicted successor of v in the given direction (wraps mod 16).
  function automatic logic [3:0] step_val(input logic [3:0] v, input logic d);
    return d ? v - 4'd1 : v + 4'd1;
  endfunction

  logic [SYNC_STAGES-1:0][6:0] sync_q;
  logic [6:0]                  synced;
  logic                        strb_prev_q;
  logic                        ev_q, arm_q, dir_q;
  logic [3:0]                  obs_q;

  state_t     state_q;
  logic       match_q, mism_q;
  logic [3:0] err_q, wrap_q, cons_q, exp_q;
  logic [4:0] cons_nx;
  logic       unused_ok;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign cons_nx = {1'b0, cons_q} + 5'd1;

  // Pins not consumed by the checker.
  assign unused_ok = &{1'b0, bus.uio_in, bus.ena, bus.ui_in[7]};

  // Multi-flop synchronizer on ui_in[6:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ui_in[6:0]};
  end

  // Rising-edge strobe detect. Count, direction and arm are captured in the
  // same stage, so arm and the event reach the FSM together and arm can win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_prev_q <= 1'b0;
      ev_q        <= 1'b0;
      arm_q       <= 1'b0;
      dir_q       <= 1'b0;
      obs_q       <= '0;
    end else begin
      strb_prev_q <= synced[4];
      ev_q        <= synced[4] & ~strb_prev_q;
      arm_q       <= synced[5];
      dir_q       <= synced[6];
      obs_q       <= synced[3:0];
    end
  end

  // Checker FSM with registered pulses and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      match_q <= 1'b0;
      mism_q  <= 1'b0;
      err_q   <= '0;
      wrap_q  <= '0;
      cons_q  <= '0;
      exp_q   <= '0;
    end else begin
      match_q <= 1'b0;
      mism_q  <= 1'b0;
      if (!arm_q) begin
        state_q <= IDLE;
        err_q   <= '0;
        wrap_q  <= '0;
        cons_q  <= '0;
        exp_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: state_q <= SYNC;
          SYNC: if (ev_q) begin
            exp_q   <= step_val(obs_q, dir_q);
            state_q <= TRACK;
          end
          TRACK: if (ev_q) begin
            if (obs_q == exp_q) begin
              match_q <= 1'b1;
              cons_q  <= '0;
              exp_q   <= step_val(obs_q, dir_q);
              if ((!dir_q && obs_q == 4'd0) || (dir_q && obs_q == 4'hF))
                wrap_q <= wrap_q + 4'd1;
            end else begin
              mism_q <= 1'b1;
              if (err_q != 4'hF) err_q <= err_q + 4'd1;
              cons_q <= cons_nx[3:0];
              if (cons_nx >= 5'(FAULT_THRESH)) state_q <= FAULT;
`ifdef CHECKER_RESYNC_EN
              exp_q <= step_val(obs_q, dir_q);
`else
              exp_q <= step_val(exp_q, dir_q);
`endif
            end
          end
          FAULT: ;  // sticky until arm drops
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.uo_out  = {state_q == FAULT, state_q == TRACK, mism_q, match_q, err_q};
  assign bus.uio_out = {wrap_q, exp_q};
  assign bus.uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_akaur014_count_checker.sv
// Directed bench for the count checker. Expected pulses are queued when a
// strobe is driven and compared against what the pins show in the window
// that follows.
module tb_tt_um_akaur014_count_checker;

  typedef struct packed {logic m; logic mm;} pulse_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] cnt = '0;
  logic str = 1'b0, arm = 1'b0, dir = 1'b0;
  int checks = 0, errors = 0;
  pulse_t sb[$];
  logic [3:0] e;

  tt_um_akaur014_count_checker_if bus();

  assign bus.ui_in  = {1'b0, dir, arm, str, cnt};
  assign bus.uio_in = 8'h00;
  assign bus.ena    = 1'b1;

  tt_um_akaur014_count_checker dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Watches six cycles after the strobe rises and checks the queued pulse.
  task automatic observe();
    int nm = 0, nmm = 0, idx = 0;
    pulse_t w;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bus.uo_out[4]) begin nm++;  idx = i; end
      if (bus.uo_out[5]) begin nmm++; idx = i; end
    end
    w = sb.pop_front();
    chk("match_pulses", nm, {31'd0, w.m});
    chk("mismatch_pulses", nmm, {31'd0, w.mm});
    if (w.m || w.mm) chk("pulse_latency", idx, 4);
  endtask

  task automatic step(input logic [3:0] c, input logic d, input logic a,
                      input logic m, input logic mm, input logic hold);
    @(negedge clk);
    cnt = c; dir = d;
    @(negedge clk);
    str = 1'b1; arm = a;
    sb.push_back('{m: m, mm: mm});
    observe();
    if (!hold) begin
      str = 1'b0;
      wait_n(2);
    end
  endtask

  task automatic rearm();
    @(negedge clk); arm = 1'b0; wait_n(5);
    chk("rearm_uo", bus.uo_out, 8'h00);
    chk("rearm_uio", bus.uio_out, 8'h00);
    arm = 1'b1; wait_n(5);
  endtask

  initial begin
    // Reset state
    wait_n(2);
    chk("reset_uo", bus.uo_out, 8'h00);
    chk("reset_uio", bus.uio_out, 8'h00);
    chk("reset_oe", bus.uio_oe, 8'hFF);
    rst_n = 1'b1;
    arm = 1'b1; wait_n(5);
    chk("sync_not_locked", bus.uo_out[6], 1'b0);

    // Basic up count 5,6,7,8
    step(4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(4'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("basic_locked", bus.uo_out[6], 1'b1);
    chk("basic_err", bus.uo_out[3:0], 4'd0);
    chk("basic_exp", bus.uio_out[3:0], 4'd9);

    // Wrap up
    rearm();
    step(4'd14, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'd15, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(4'd1,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("wrap_up", bus.uio_out[7:4], 4'd1);

    // Wrap down
    rearm();
    step(4'd1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(4'd15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("wrap_down", bus.uio_out[7:4], 4'd1);
    chk("wrap_down_exp", bus.uio_out[3:0], 4'd14);

    // Skipped count 2,3,5,6,7
    rearm();
    step(4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef CHECKER_RESYNC_EN
    step(4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(4'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(4'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("skip_err", bus.uo_out[3:0], 4'd1);
    chk("skip_locked", bus.uo_out[6], 1'b1);
    chk("skip_fault", bus.uo_out[7], 1'b0);
`else
    step(4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(4'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(4'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("skip_err", bus.uo_out[3:0], 4'd3);
    chk("skip_locked", bus.uo_out[6], 1'b0);
    chk("skip_fault", bus.uo_out[7], 1'b1);
    step(4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fault_sticky", bus.uo_out[7], 1'b1);
`endif

    // Error count saturation: alternate mismatch/match so the consecutive
    // count never reaches the fault threshold.
    rearm();
    step(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e = 4'd1;
    for (int i = 0; i < 20; i++) begin
      step(e + 4'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef CHECKER_RESYNC_EN
      e = e + 4'd9;
`else
      e = e + 4'd1;
`endif
      step(e, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      e = e + 4'd1;
    end
    chk("sat_err", bus.uo_out[3:0], 4'd15);
    chk("sat_locked", bus.uo_out[6], 1'b1);
    chk("sat_exp", bus.uio_out[3:0], e);

    // Arm falling together with a step event: arm wins
    step(e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("prio_uo", bus.uo_out, 8'h00);
    chk("prio_uio", bus.uio_out, 8'h00);

    // Async reset mid-TRACK with the strobe held through release
    arm = 1'b1; wait_n(5);
    step(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("pre_rst_locked", bus.uo_out[6], 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("async_uo", bus.uo_out, 8'h00);
    chk("async_uio", bus.uio_out, 8'h00);
    wait_n(2);
    rst_n = 1'b1;
    sb.push_back('{m: 1'b0, mm: 1'b0});
    observe();
    chk("post_rst_locked", bus.uo_out[6], 1'b0);
    chk("post_rst_exp", bus.uio_out[3:0], 4'd0);
    str = 1'b0; wait_n(2);
    step(4'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("resume_locked", bus.uo_out[6], 1'b1);
    chk("resume_exp", bus.uio_out[3:0], 4'd11);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
